// File: rtl/ysyx_24100029_axi_arbiter_if.sv
// ysyx_24100029_axi_arbiter_if
// ---------------------------------------------------------------------------
// Purpose: full AXI4 bundle (AR, R, AW, W, B) shared by the arbiter's three
// ports. Only the handshake and payload fields the arbiter routes are present.
//
// Modports:
//   master   - the side that issues requests (drives *valid on AR/AW/W, rready, bready)
//   slave    - the side that answers requests (drives *ready on AR/AW/W, rvalid, bvalid)
//   rd_slave - read-only subset of slave, used for the instruction-fetch port
//
// Parameters:
//   ADDR_W - address width of AR/AW
//   DATA_W - data width of R/W (wstrb is DATA_W/8 bits)
// ---------------------------------------------------------------------------
interface ysyx_24100029_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;
  logic [3:0] bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

  modport rd_slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

endinterface

// File: rtl/ysyx_24100029_axi_arbiter.sv
// ysyx_24100029_axi_arbiter
// ---------------------------------------------------------------------------
// Purpose: shares the core's single AXI4 memory port between the instruction
// fetch path (read only) and the load/store unit (read and write). Exactly
// one transaction is outstanding at a time; contending reads are granted
// round-robin.
//
// Ports:
//   clock - core clock, all state updates on the rising edge
//   reset - asynchronous, active-low reset
//   ifu   - instruction-fetch read port (AR/R only), arbiter is the slave
//   lsu   - load/store port (AR/R/AW/W/B), arbiter is the slave
//   mem   - downstream port toward the SoC/crossbar, arbiter is the master
//
// All channel routing in AR/R/W/B is combinational; there is no buffering.
// ---------------------------------------------------------------------------
module ysyx_24100029_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_24100029_axi_arbiter_if.rd_slave     ifu,
  ysyx_24100029_axi_arbiter_if.slave        lsu,
  ysyx_24100029_axi_arbiter_if.master       mem
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_W,
    S_B
  } state_t;

  state_t state, state_next;

  // grant_lsu is both the current grant and the round-robin history: it is
  // loaded on every grant edge, so outside IDLE it selects the routed master
  // and inside IDLE it is the last master granted. It resets to LSU so the
  // instruction fetch wins the first contention.
  logic grant_lsu, grant_lsu_next;
  logic aw_done, aw_done_next;
  logic w_done, w_done_next;

  logic ifu_req, lsu_req, pick_lsu;
  logic ar_valid_sel, r_ready_sel;
  logic aw_fire, w_fire;

  // State register and handshake flags. Reset is asynchronous so a bus in
  // mid-transaction is released immediately; the transaction is abandoned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant_lsu <= 1'b1;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state     <= state_next;
      grant_lsu <= grant_lsu_next;
      aw_done   <= aw_done_next;
      w_done    <= w_done_next;
    end
  end

  // Next-state logic and the channel muxes. Every output defaults to idle
  // (valids/readies low, payload zero) so that only the granted master and
  // the channel of the current state ever see the slave. An LSU holding both
  // arvalid and awvalid is sent down the write path first; its read is
  // picked up on a later IDLE cycle because it keeps arvalid asserted.
  always_comb begin
    state_next     = state;
    grant_lsu_next = grant_lsu;
    aw_done_next   = aw_done;
    w_done_next    = w_done;

    ifu_req  = ifu.arvalid;
    lsu_req  = lsu.arvalid | lsu.awvalid;
    pick_lsu = lsu_req & (~ifu_req | ~grant_lsu);

    ar_valid_sel = grant_lsu ? lsu.arvalid : ifu.arvalid;
    r_ready_sel  = grant_lsu ? lsu.rready  : ifu.rready;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;

    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.rdata   = DATA_ZERO;
    ifu.rresp   = 2'b00;
    ifu.rlast   = 1'b0;
    ifu.rid     = 4'h0;

    lsu.arready = 1'b0;
    lsu.rvalid  = 1'b0;
    lsu.rdata   = DATA_ZERO;
    lsu.rresp   = 2'b00;
    lsu.rlast   = 1'b0;
    lsu.rid     = 4'h0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bvalid  = 1'b0;
    lsu.bresp   = 2'b00;
    lsu.bid     = 4'h0;

    mem.arvalid = 1'b0;
    mem.araddr  = ADDR_ZERO;
    mem.arid    = 4'h0;
    mem.arlen   = 8'h00;
    mem.arsize  = 3'b000;
    mem.arburst = 2'b00;
    mem.rready  = 1'b0;
    mem.awvalid = 1'b0;
    mem.awaddr  = ADDR_ZERO;
    mem.awid    = 4'h0;
    mem.awlen   = 8'h00;
    mem.awsize  = 3'b000;
    mem.awburst = 2'b00;
    mem.wvalid  = 1'b0;
    mem.wdata   = DATA_ZERO;
    mem.wstrb   = '0;
    mem.wlast   = 1'b0;
    mem.bready  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (ifu_req | lsu_req) begin
          grant_lsu_next = pick_lsu;
          state_next     = (pick_lsu & lsu.awvalid) ? S_W : S_AR;
        end
      end

      S_AR: begin
        mem.arvalid = ar_valid_sel;
        if (grant_lsu) begin
          mem.araddr  = lsu.araddr;
          mem.arid    = lsu.arid;
          mem.arlen   = lsu.arlen;
          mem.arsize  = lsu.arsize;
          mem.arburst = lsu.arburst;
          lsu.arready = mem.arready;
        end else begin
          mem.araddr  = ifu.araddr;
          mem.arid    = ifu.arid;
          mem.arlen   = ifu.arlen;
          mem.arsize  = ifu.arsize;
          mem.arburst = ifu.arburst;
          ifu.arready = mem.arready;
        end
        if (ar_valid_sel & mem.arready) begin
          state_next = S_R;
        end
      end

      S_R: begin
        mem.rready = r_ready_sel;
        if (grant_lsu) begin
          lsu.rvalid = mem.rvalid;
          lsu.rdata  = mem.rdata;
          lsu.rresp  = mem.rresp;
          lsu.rlast  = mem.rlast;
          lsu.rid    = mem.rid;
        end else begin
          ifu.rvalid = mem.rvalid;
          ifu.rdata  = mem.rdata;
          ifu.rresp  = mem.rresp;
          ifu.rlast  = mem.rlast;
          ifu.rid    = mem.rid;
        end
        if (mem.rvalid & r_ready_sel & mem.rlast) begin
          state_next = S_IDLE;
        end
      end

      S_W: begin
        // A channel that has already handshaken is masked off so a master
        // still holding valid cannot issue a second address or last beat.
        mem.awvalid = lsu.awvalid & ~aw_done;
        mem.awaddr  = lsu.awaddr;
        mem.awid    = lsu.awid;
        mem.awlen   = lsu.awlen;
        mem.awsize  = lsu.awsize;
        mem.awburst = lsu.awburst;
        lsu.awready = mem.awready & ~aw_done;

        mem.wvalid  = lsu.wvalid & ~w_done;
        mem.wdata   = lsu.wdata;
        mem.wstrb   = lsu.wstrb;
        mem.wlast   = lsu.wlast;
        lsu.wready  = mem.wready & ~w_done;

        aw_fire = lsu.awvalid & mem.awready & ~aw_done;
        w_fire  = lsu.wvalid & mem.wready & lsu.wlast & ~w_done;
        if (aw_fire) begin
          aw_done_next = 1'b1;
        end
        if (w_fire) begin
          w_done_next = 1'b1;
        end
        if ((aw_done | aw_fire) & (w_done | w_fire)) begin
          state_next = S_B;
        end
      end

      S_B: begin
        lsu.bvalid = mem.bvalid;
        lsu.bresp  = mem.bresp;
        lsu.bid    = mem.bid;
        mem.bready = lsu.bready;
        if (mem.bvalid & lsu.bready) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100029_axi_arbiter.sv
// tb_ysyx_24100029_axi_arbiter
// ---------------------------------------------------------------------------
// Bench for the two-master AXI arbiter. A table of read transactions drives
// the round-robin and routing behaviour; hand-written sequences cover the
// write path, write-before-read ordering and asynchronous reset mid-burst.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24100029_axi_arbiter;

  logic clock;
  logic reset;

  int tests;
  int failed;

  ysyx_24100029_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
  ysyx_24100029_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
  ysyx_24100029_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  ysyx_24100029_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .ifu   (ifu_bus),
    .lsu   (lsu_bus),
    .mem   (mem_bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        ifu_req;
    logic        lsu_req;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic [7:0]  lsu_len;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [31:0] data;
    logic [1:0]  resp;
    int          stall_beat;
  } rd_vec_t;

  rd_vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic initBuses();
    ifu_bus.arvalid = 0; ifu_bus.araddr = 0; ifu_bus.arid = 4'h2; ifu_bus.arlen = 0;
    ifu_bus.arsize = 3'b010; ifu_bus.arburst = 2'b01; ifu_bus.rready = 1;
    ifu_bus.awvalid = 0; ifu_bus.awaddr = 0; ifu_bus.awid = 0; ifu_bus.awlen = 0;
    ifu_bus.awsize = 0; ifu_bus.awburst = 0; ifu_bus.wvalid = 0; ifu_bus.wdata = 0;
    ifu_bus.wstrb = 0; ifu_bus.wlast = 0; ifu_bus.bready = 0;
    ifu_bus.awready = 0; ifu_bus.wready = 0; ifu_bus.bvalid = 0; ifu_bus.bresp = 0; ifu_bus.bid = 0;

    lsu_bus.arvalid = 0; lsu_bus.araddr = 0; lsu_bus.arid = 4'h5; lsu_bus.arlen = 0;
    lsu_bus.arsize = 3'b010; lsu_bus.arburst = 2'b01; lsu_bus.rready = 1;
    lsu_bus.awvalid = 0; lsu_bus.awaddr = 0; lsu_bus.awid = 4'h5; lsu_bus.awlen = 0;
    lsu_bus.awsize = 3'b010; lsu_bus.awburst = 2'b01; lsu_bus.wvalid = 0; lsu_bus.wdata = 0;
    lsu_bus.wstrb = 0; lsu_bus.wlast = 0; lsu_bus.bready = 1;

    mem_bus.arready = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0; mem_bus.rresp = 0;
    mem_bus.rlast = 0; mem_bus.rid = 0; mem_bus.awready = 0; mem_bus.wready = 0;
    mem_bus.bvalid = 0; mem_bus.bresp = 0; mem_bus.bid = 0;
  endtask

  // Raise the read requests of one table entry; a master already waiting
  // keeps its original address.
  task automatic applyStimulus(input rd_vec_t v);
    if (v.ifu_req && !ifu_bus.arvalid) begin
      ifu_bus.araddr  = v.ifu_addr;
      ifu_bus.arlen   = 8'h00;
      ifu_bus.arvalid = 1'b1;
    end
    if (v.lsu_req && !lsu_bus.arvalid) begin
      lsu_bus.araddr  = v.lsu_addr;
      lsu_bus.arlen   = v.lsu_len;
      lsu_bus.arvalid = 1'b1;
    end
  endtask

  // Act as the downstream slave for one read: wait for arvalid, accept it,
  // return exp_len+1 beats of data+beat, optionally stalling the master's
  // rready for one cycle at stall_beat. Returns cycles waited for arvalid.
  task automatic serve_read(input logic exp_lsu, input logic [31:0] exp_addr,
                            input logic [7:0] exp_len, input logic [31:0] data,
                            input logic [1:0] resp, input int stall_beat,
                            input string tag, output int lat);
    logic [3:0] exp_id;
    int beat;
    bit stalled;
    logic m_rready;
    exp_id  = exp_lsu ? 4'h5 : 4'h2;
    lat     = 0;
    beat    = 0;
    stalled = 0;
    #1;
    while (!mem_bus.arvalid && lat < 20) begin
      step();
      #1;
      lat++;
    end
    checkOutput({tag, " arvalid"}, mem_bus.arvalid, 1);
    if (mem_bus.arvalid) begin
      checkOutput({tag, " araddr"}, mem_bus.araddr, exp_addr);
      checkOutput({tag, " arid"}, mem_bus.arid, exp_id);
      checkOutput({tag, " arlen"}, mem_bus.arlen, exp_len);
      mem_bus.arready = 1'b1;
      #1;
      checkOutput({tag, " granted arready"}, exp_lsu ? lsu_bus.arready : ifu_bus.arready, 1);
      checkOutput({tag, " other arready"}, exp_lsu ? ifu_bus.arready : lsu_bus.arready, 0);
      step();
      mem_bus.arready = 1'b0;
      if (exp_lsu) lsu_bus.arvalid = 1'b0;
      else ifu_bus.arvalid = 1'b0;
      while (beat <= int'(exp_len)) begin
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = data + beat;
        mem_bus.rresp  = resp;
        mem_bus.rlast  = (beat == int'(exp_len));
        mem_bus.rid    = exp_id;
        if (beat == stall_beat && !stalled) begin
          m_rready = 1'b0;
          stalled  = 1;
        end else begin
          m_rready = 1'b1;
        end
        if (exp_lsu) lsu_bus.rready = m_rready;
        else ifu_bus.rready = m_rready;
        #1;
        checkOutput($sformatf("%s rvalid b%0d", tag, beat), exp_lsu ? lsu_bus.rvalid : ifu_bus.rvalid, 1);
        checkOutput($sformatf("%s rdata b%0d", tag, beat), exp_lsu ? lsu_bus.rdata : ifu_bus.rdata, data + beat);
        checkOutput($sformatf("%s rresp b%0d", tag, beat), exp_lsu ? lsu_bus.rresp : ifu_bus.rresp, resp);
        checkOutput($sformatf("%s rid b%0d", tag, beat), exp_lsu ? lsu_bus.rid : ifu_bus.rid, exp_id);
        checkOutput($sformatf("%s other rvalid b%0d", tag, beat), exp_lsu ? ifu_bus.rvalid : lsu_bus.rvalid, 0);
        checkOutput($sformatf("%s slave rready b%0d", tag, beat), mem_bus.rready, m_rready);
        step();
        if (m_rready) beat++;
      end
      mem_bus.rvalid = 1'b0;
      mem_bus.rlast  = 1'b0;
      ifu_bus.rready = 1'b1;
      lsu_bus.rready = 1'b1;
      #1;
      checkOutput({tag, " idle after rlast"}, {mem_bus.arvalid, mem_bus.rready}, 2'b00);
    end
  endtask

  initial begin
    int lat;
    tests  = 0;
    failed = 0;

    vecs[0] = '{1'b1, 1'b1, 32'h3000_0000, 32'h8000_0010, 8'd0, 1'b0, 32'h3000_0000, 8'd0, 32'hA000_0000, 2'b00, -1};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         32'h0,         8'd0, 1'b1, 32'h8000_0010, 8'd0, 32'hB000_0000, 2'b00, -1};
    vecs[2] = '{1'b1, 1'b1, 32'h3000_0004, 32'h8000_0020, 8'd0, 1'b0, 32'h3000_0004, 8'd0, 32'hA100_0000, 2'b00, -1};
    vecs[3] = '{1'b1, 1'b0, 32'h3000_0008, 32'h0,         8'd0, 1'b1, 32'h8000_0020, 8'd0, 32'hB100_0000, 2'b01, -1};
    vecs[4] = '{1'b0, 1'b1, 32'h0,         32'h8000_0030, 8'd3, 1'b0, 32'h3000_0008, 8'd0, 32'hA200_0000, 2'b00, -1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         32'h0,         8'd0, 1'b1, 32'h8000_0030, 8'd3, 32'hB200_0000, 2'b00, 2};
    vecs[6] = '{1'b1, 1'b0, 32'h3000_000C, 32'h0,         8'd0, 1'b0, 32'h3000_000C, 8'd0, 32'hA300_0000, 2'b11, -1};

    // Reset state: every valid/ready toward either side is low even with
    // requests and stray slave responses present.
    reset = 1'b0;
    initBuses();
    ifu_bus.arvalid = 1; lsu_bus.arvalid = 1; lsu_bus.awvalid = 1; lsu_bus.wvalid = 1;
    mem_bus.arready = 1; mem_bus.rvalid = 1; mem_bus.awready = 1; mem_bus.wready = 1; mem_bus.bvalid = 1;
    #3;
    checkOutput("reset slave valids", {mem_bus.arvalid, mem_bus.awvalid, mem_bus.wvalid, mem_bus.rready, mem_bus.bready}, 0);
    checkOutput("reset master valids", {ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.rvalid,
                                        lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid}, 0);
    initBuses();
    @(negedge clock);
    reset = 1'b1;
    step();

    // Round-robin reads driven from the table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      serve_read(vecs[i].exp_lsu, vecs[i].exp_addr, vecs[i].exp_len, vecs[i].data,
                 vecs[i].resp, vecs[i].stall_beat, $sformatf("vec%0d", i), lat);
      checkOutput($sformatf("vec%0d grant latency", i), lat, 1);
    end

    // LSU write: awready held off for three cycles, wready immediate.
    lsu_bus.awaddr = 32'h8000_1000; lsu_bus.awlen = 0; lsu_bus.awvalid = 1;
    lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wstrb = 4'hF; lsu_bus.wlast = 1; lsu_bus.wvalid = 1;
    mem_bus.awready = 0; mem_bus.wready = 1;
    step();
    #1;
    checkOutput("wr W1 awvalid", mem_bus.awvalid, 1);
    checkOutput("wr W1 awaddr", mem_bus.awaddr, 32'h8000_1000);
    checkOutput("wr W1 wvalid", mem_bus.wvalid, 1);
    checkOutput("wr W1 wdata", mem_bus.wdata, 32'hDEAD_BEEF);
    checkOutput("wr W1 wstrb", mem_bus.wstrb, 4'hF);
    checkOutput("wr W1 lsu ready", {lsu_bus.awready, lsu_bus.wready}, 2'b01);
    checkOutput("wr W1 no arvalid", mem_bus.arvalid, 0);
    step();
    #1;
    checkOutput("wr W2 wvalid masked", mem_bus.wvalid, 0);
    checkOutput("wr W2 wready masked", lsu_bus.wready, 0);
    checkOutput("wr W2 awvalid held", mem_bus.awvalid, 1);
    step();
    #1;
    checkOutput("wr W3 no bready", {mem_bus.bready, lsu_bus.bvalid}, 0);
    step();
    mem_bus.awready = 1;
    #1;
    checkOutput("wr W4 awready", lsu_bus.awready, 1);
    step();
    lsu_bus.awvalid = 0; lsu_bus.wvalid = 0; lsu_bus.wlast = 0;
    mem_bus.awready = 0; mem_bus.wready = 0;
    mem_bus.bvalid = 1; mem_bus.bresp = 2'b00; mem_bus.bid = 4'h5;
    #1;
    checkOutput("wr B bvalid", lsu_bus.bvalid, 1);
    checkOutput("wr B bresp", lsu_bus.bresp, 2'b00);
    checkOutput("wr B bid", lsu_bus.bid, 4'h5);
    checkOutput("wr B bready", mem_bus.bready, 1);
    checkOutput("wr B aw masked", mem_bus.awvalid, 0);
    step();
    #1;
    checkOutput("wr idle stray bvalid", {lsu_bus.bvalid, mem_bus.bready}, 2'b00);
    mem_bus.bvalid = 0; mem_bus.bid = 0;

    // LSU presents read and write together: write first, then the read,
    // whose error response must pass through untouched.
    lsu_bus.awaddr = 32'h8000_2000; lsu_bus.awvalid = 1;
    lsu_bus.wdata = 32'h1234_5678; lsu_bus.wlast = 1; lsu_bus.wvalid = 1;
    lsu_bus.araddr = 32'h8000_0040; lsu_bus.arlen = 0; lsu_bus.arvalid = 1;
    mem_bus.awready = 1; mem_bus.wready = 1;
    step();
    #1;
    checkOutput("wr_rd write first", {mem_bus.awvalid, mem_bus.wvalid, mem_bus.arvalid}, 3'b110);
    step();
    lsu_bus.awvalid = 0; lsu_bus.wvalid = 0; lsu_bus.wlast = 0;
    mem_bus.awready = 0; mem_bus.wready = 0; mem_bus.bvalid = 1; mem_bus.bid = 4'h5;
    #1;
    checkOutput("wr_rd bvalid", lsu_bus.bvalid, 1);
    step();
    mem_bus.bvalid = 0;
    serve_read(1'b1, 32'h8000_0040, 8'd0, 32'hC000_0000, 2'b10, -1, "wr_rd read", lat);
    checkOutput("wr_rd read latency", lat, 1);

    // Asynchronous reset during an IFU burst.
    ifu_bus.araddr = 32'h3000_0100; ifu_bus.arlen = 8'd3; ifu_bus.arvalid = 1;
    step();
    #1;
    checkOutput("rst AR arvalid", mem_bus.arvalid, 1);
    mem_bus.arready = 1;
    step();
    mem_bus.arready = 0; ifu_bus.arvalid = 0; ifu_bus.arlen = 0;
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h5A5A_0000; mem_bus.rlast = 0; mem_bus.rid = 4'h2;
    #1;
    checkOutput("rst R before", {mem_bus.rready, ifu_bus.rvalid}, 2'b11);
    step();
    lsu_bus.araddr = 32'h8000_0050; lsu_bus.arlen = 0; lsu_bus.arvalid = 1;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst async drop", {mem_bus.rready, mem_bus.arvalid, ifu_bus.rvalid, lsu_bus.rvalid,
                                   ifu_bus.arready, lsu_bus.arready}, 0);
    mem_bus.rvalid = 0; mem_bus.rid = 0;
    ifu_bus.araddr = 32'h3000_0200; ifu_bus.arvalid = 1;
    step();
    step();
    @(negedge clock);
    reset = 1'b1;
    step();
    serve_read(1'b0, 32'h3000_0200, 8'd0, 32'hD000_0000, 2'b00, -1, "post_rst ifu", lat);
    serve_read(1'b1, 32'h8000_0050, 8'd0, 32'hE000_0000, 2'b00, -1, "post_rst lsu", lat);
    checkOutput("post_rst lsu latency", lat, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_axi_arbiter.md
# ysyx_24100029_axi_arbiter

Two-master to one-slave AXI4 arbiter that shares the core's single memory bus between the instruction-fetch path (IFU/icache, read-only) and the load/store unit (read and write). It sits between the icache's downstream AXI port, the LSU's AXI port, and the SoC/crossbar AXI master port. It serialises the two masters onto the slave: exactly one transaction is outstanding at a time, and reads are granted round-robin.

## Interface
Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels

Ports:
- clock  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ifu_ar{valid,ready,addr,id,len,size,burst}  in/out  1/1/ADDR_W/4/8/3/2  IFU read-address channel; arready is the only output
- ifu_r{valid,ready,data,resp,last,id}  mixed  1/1/DATA_W/2/1/4  IFU read-data channel; rready is the only input
- lsu_ar*  same as ifu_ar*  LSU read-address channel
- lsu_r*  same as ifu_r*  LSU read-data channel
- lsu_aw{valid,ready,addr,id,len,size,burst}  mixed  1/1/ADDR_W/4/8/3/2  LSU write-address channel
- lsu_w{valid,ready,data,strb,last}  mixed  1/1/DATA_W/4/1  LSU write-data channel
- lsu_b{valid,ready,resp,id}  mixed  1/1/2/4  LSU write-response channel
- ar*, r*, aw*, w*, b*  mixed  as above  slave-side AXI4 master port toward the SoC

## Operation
- FSM states:
  - IDLE: sample requests.
  - AR: forward the granted master's AR to the slave.
  - R: route R beats.
  - W: forward LSU AW and W concurrently.
  - B: route B.
- Requests:
  - IFU request = ifu_arvalid.
  - LSU request = lsu_arvalid | lsu_awvalid.
  - If both lsu_arvalid and lsu_awvalid are high, the LSU write is taken first.
- Arbitration (IDLE only):
  - One request only: grant that master.
  - Both masters request: grant the master not equal to last_grant.
  - last_grant updates on every grant.
  - Reset value of last_grant is LSU, so IFU wins the first contention after reset.
- Grant actions:
  - IDLE → AR for a read grant.
  - IDLE → W for an LSU write grant.
  - The grant register and the read/write selection are latched on the grant edge.
- AR state:
  - Slave ar* = granted master's ar*, including arid and arlen passed through unchanged.
  - Granted master's arready = slave arready.
  - arvalid & arready → R.
- R state:
  - Slave rready = granted master's rready.
  - Granted master's r* = slave r*; rresp is passed unchanged, errors are not filtered.
  - rvalid & rready & rlast → IDLE.
  - Multi-beat bursts (arlen > 0) are routed beat by beat.
- W state:
  - Slave aw* and w* = LSU aw* and w*.
  - Flags aw_done and w_done are set on, respectively, the aw handshake and the w handshake with wlast.
  - After a channel's done flag is set, that channel's slave valid and the corresponding LSU ready are forced to 0.
  - When both flags are set (including the same cycle) → B.
  - Flags clear on the B → IDLE transition.
- B state:
  - LSU b* ↔ slave b*.
  - bvalid & bready → IDLE.
- Non-granted master and non-active channels:
  - Master-facing arready/rvalid/awready/wready/bvalid are 0.
  - Slave-facing arvalid/awvalid/wvalid/rready/bready are 0.
  - Addresses and data are don't-care but driven 0.
  - A stray slave rvalid or bvalid in IDLE is not forwarded and not accepted.
- Masters must hold valid and payload stable until ready (AXI rule). The arbiter samples requests only in IDLE.

## Timing
- Reset values:
  - FSM = IDLE, last_grant = LSU, aw_done = w_done = 0.
  - All slave-facing valid/ready outputs are 0; all master-facing valid/ready outputs are 0.
  - Reset takes effect asynchronously, mid-transaction included. The in-flight transaction is abandoned, not replayed.
- Arbitration latency: request high in IDLE at cycle N → slave arvalid (or awvalid/wvalid) high in cycle N+1.
- Minimum single-beat read (arready in cycle N+1, rvalid+rlast in cycle N+2):
  - FSM returns to IDLE at N+3.
  - The next grant's slave valid appears at N+4.
- Routing during AR/R/W/B is purely combinational through the muxes; no added latency per beat and no buffering.
- A request that arrives while the FSM is busy waits in place; it is never dropped.
- Requests that arrive on the cycle the FSM returns to IDLE are arbitrated in that IDLE cycle.

## Test plan
- Simultaneous ifu_arvalid (0x3000_0000) and lsu_arvalid (0x8000_0010) right after reset → slave araddr = 0x3000_0000 first. After its rlast beat, the slave shows 0x8000_0010. Each master receives only its own rdata.
- IFU re-requests immediately after each completion while an LSU read is pending → grants alternate IFU, LSU, IFU. Neither master is granted twice in a row while the other is waiting.
- LSU read with arlen=3, rvalid every cycle, lsu_rready low on beat 2 for one cycle → 4 beats reach the LSU in order. Slave rready is low in that stall cycle. ifu_rvalid stays 0. FSM is in IDLE the cycle after the rlast handshake.
- LSU write with awready delayed 3 cycles and wready immediate (wlast=1) → the w handshake completes first and slave wvalid then drops. B is entered after the aw handshake. bresp=2'b00 reaches the LSU. FSM returns to IDLE after the b handshake.
- LSU presents arvalid and awvalid together, IFU idle → the write is executed first and the read is granted in the next IDLE. A slave rresp=2'b10 on that read is delivered unchanged to lsu_rresp.
- Assert reset (low) in the R state mid-burst → slave rready, arvalid and all master valids drop in the same cycle without waiting for a clock edge. After release, contending requests grant IFU first.
